multiply_seq_mult: RTL and testbench

MULTIPLY_SEQ_MULT -- requirements
Module: multiply_seq_mult

---
 rtl/multiply_seq_mult.sv | 171 +++++++++++++++++
 tb/tb_multiply_seq_mult.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multiply_seq_mult.sv
// multiply_seq_mult: sequential shift-add multiplier for a 33-bit special
// format (sign, unbiased exponent, 24-bit mantissa with hidden bit).
// Handshaked input/output. A pass-through request skips the arithmetic.
// Optional build macro MULT_RADIX4_EN: consume two multiplier bits per edge
// (12 CALC edges) instead of one (24 CALC edges). Results are identical.
module multiply_seq_mult #(
  parameter logic no_idle  = 1'b0,
  parameter logic put_idle = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [32:0] aout_Special,
  input  logic [32:0] bout_Special,
  input  logic        idle_Special,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        idle_Multiply,
  output logic [32:0] zout_Multiply,
  output logic [49:0] productout_Multiply
);

`ifdef MULT_RADIX4_EN
  localparam int K = 2;
`else
  localparam int K = 1;
`endif
  localparam int CW = 5;
  localparam logic [CW-1:0] N_CNT = CW'(24 / K);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_reg, state_next;
  logic [47:0]     acc_reg, acc_next;
  logic [47:0]     mcand_reg, mcand_next;
  logic [23:0]     mplier_reg, mplier_next;
`ifdef MULT_RADIX4_EN
  logic [47:0]     triple_reg, triple_next;
`endif
  logic [CW-1:0]   count_reg, count_next;
  logic            sign_reg, sign_next;
  logic [7:0]      exp_reg, exp_next;
  logic            out_valid_reg, out_valid_next;
  logic            idle_reg, idle_next;
  logic [32:0]     zout_reg, zout_next;
  logic [49:0]     prod_reg, prod_next;
  logic [47:0]     pp;

  assign in_ready            = (state_reg == IDLE);
  assign out_valid           = out_valid_reg;
  assign idle_Multiply       = idle_reg;
  assign zout_Multiply       = zout_reg;
  assign productout_Multiply = prod_reg;

  // Next-state, datapath and output-load decisions
  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_reg;
    mcand_next     = mcand_reg;
    mplier_next    = mplier_reg;
`ifdef MULT_RADIX4_EN
    triple_next    = triple_reg;
`endif
    count_next     = count_reg;
    sign_next      = sign_reg;
    exp_next       = exp_reg;
    out_valid_next = out_valid_reg;
    idle_next      = idle_reg;
    zout_next      = zout_reg;
    prod_next      = prod_reg;

    // Partial product selected by the low multiplier bit(s)
`ifdef MULT_RADIX4_EN
    case (mplier_reg[1:0])
      2'd1:    pp = mcand_reg;
      2'd2:    pp = mcand_reg << 1;
      2'd3:    pp = triple_reg;
      default: pp = '0;
    endcase
`else
    pp = mplier_reg[0] ? mcand_reg : '0;
`endif

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          if (idle_Special == put_idle) begin
            // Pass-through: operand A goes straight to the result
            zout_next      = aout_Special;
            prod_next      = '0;
            idle_next      = 1'b1;
            out_valid_next = 1'b1;
            state_next     = DONE;
          end else if (idle_Special == no_idle) begin
            sign_next   = aout_Special[32] ^ bout_Special[32];
            exp_next    = aout_Special[31:24] + bout_Special[31:24] + 8'd1;
            acc_next    = '0;
            mcand_next  = {24'd0, aout_Special[23:0]};
            mplier_next = bout_Special[23:0];
`ifdef MULT_RADIX4_EN
            triple_next = {24'd0, aout_Special[23:0]} + {23'd0, aout_Special[23:0], 1'b0};
`endif
            count_next  = N_CNT;
            state_next  = CALC;
          end
        end
      end
      CALC: begin
        acc_next    = acc_reg + pp;
        mcand_next  = mcand_reg << K;
        mplier_next = mplier_reg >> K;
`ifdef MULT_RADIX4_EN
        triple_next = triple_reg << 2;
`endif
        count_next  = count_reg - 1'b1;
        // Final edge: publish the fully accumulated product
        if (count_reg == CW'(1)) begin
          zout_next      = {sign_reg, exp_reg, 24'd0};
          prod_next      = {acc_next, 2'b00};
          idle_next      = 1'b0;
          out_valid_next = 1'b1;
          state_next     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers; active-low reset abandons any transaction
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      mcand_reg     <= '0;
      mplier_reg    <= '0;
`ifdef MULT_RADIX4_EN
      triple_reg    <= '0;
`endif
      count_reg     <= '0;
      sign_reg      <= 1'b0;
      exp_reg       <= '0;
      out_valid_reg <= 1'b0;
      idle_reg      <= 1'b0;
      zout_reg      <= '0;
      prod_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      mcand_reg     <= mcand_next;
      mplier_reg    <= mplier_next;
`ifdef MULT_RADIX4_EN
      triple_reg    <= triple_next;
`endif
      count_reg     <= count_next;
      sign_reg      <= sign_next;
      exp_reg       <= exp_next;
      out_valid_reg <= out_valid_next;
      idle_reg      <= idle_next;
      zout_reg      <= zout_next;
      prod_reg      <= prod_next;
    end
  end

endmodule

// File: tb/tb_multiply_seq_mult.sv
// Scoreboard testbench for multiply_seq_mult. Expected results are pushed
// when a transaction is accepted and popped when the DUT presents a result.
module tb_multiply_seq_mult;

  localparam logic NO_IDLE = 1'b0;
  localparam logic PUT_IDLE = 1'b1;
`ifdef MULT_RADIX4_EN
  localparam int N_LAT = 12;
`else
  localparam int N_LAT = 24;
`endif

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [32:0] aout_Special;
  logic [32:0] bout_Special;
  logic        idle_Special;
  logic        out_valid;
  logic        out_ready;
  logic        idle_Multiply;
  logic [32:0] zout_Multiply;
  logic [49:0] productout_Multiply;

  typedef struct {
    logic [32:0] z;
    logic [49:0] p;
    logic        i;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  multiply_seq_mult #(.no_idle(NO_IDLE), .put_idle(PUT_IDLE)) dut (
    .clock               (clock),
    .reset               (reset),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .aout_Special        (aout_Special),
    .bout_Special        (bout_Special),
    .idle_Special        (idle_Special),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .idle_Multiply       (idle_Multiply),
    .zout_Multiply       (zout_Multiply),
    .productout_Multiply (productout_Multiply)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [32:0] model_z(input logic [32:0] a, input logic [32:0] b);
    logic [7:0] e;
    e = a[31:24] + b[31:24] + 8'd1;
    return {a[32] ^ b[32], e, 24'd0};
  endfunction

  function automatic logic [49:0] model_p(input logic [32:0] a, input logic [32:0] b);
    logic [47:0] m;
    m = 48'(a[23:0]) * 48'(b[23:0]);
    return {m, 2'b00};
  endfunction

  // Result monitor: one line per consumed result
  always @(negedge clock) begin
    if (reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("result z=%h p=%h idle=%0b", zout_Multiply, productout_Multiply, idle_Multiply);
        check("zout", zout_Multiply, e.z);
        check("product", productout_Multiply, e.p);
        check("idle", idle_Multiply, e.i);
      end
    end
  end

  // Drive one operand pair and let it be accepted at the next edge (E0)
  task automatic send(input logic [32:0] a, input logic [32:0] b, input logic idl,
                      input logic [32:0] ez, input logic [49:0] ep, input logic ei,
                      input bit do_push, input bit keep_valid);
    exp_t e;
    @(posedge clock); #1;
    aout_Special = a;
    bout_Special = b;
    idle_Special = idl;
    in_valid     = 1'b1;
    @(negedge clock);
    check("accept_ready", in_ready, 1);
    @(posedge clock);
    if (do_push) begin
      e.z = ez; e.p = ep; e.i = ei;
      sb.push_back(e);
    end
    $display("send a=%h b=%h idle=%0b", a, b, idl);
    #1;
    if (!keep_valid) in_valid = 1'b0;
  endtask

  // Count edges after E0 until out_valid; outputs must not move meanwhile
  task automatic wait_done(input int exp_lat);
    int          lat;
    logic [49:0] p0;
    logic [32:0] z0;
    bit          moved;
    lat   = 0;
    moved = 0;
    @(negedge clock);
    p0 = productout_Multiply;
    z0 = zout_Multiply;
    while (!out_valid && lat < 100) begin
      @(negedge clock);
      lat++;
      if (!out_valid && (productout_Multiply !== p0 || zout_Multiply !== z0)) moved = 1;
    end
    check("latency", lat, exp_lat);
    check("calc_hold", moved, 0);
  endtask

  task automatic run(input logic [32:0] a, input logic [32:0] b, input logic idl,
                     input logic [32:0] ez, input logic [49:0] ep, input logic ei, input int lat);
    send(a, b, idl, ez, ep, ei, 1'b1, 1'b0);
    wait_done(lat);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32:0] a, b;
    int          ghost;
    reset        = 1'b0;
    in_valid     = 1'b0;
    aout_Special = '0;
    bout_Special = '0;
    idle_Special = NO_IDLE;
    out_ready    = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_zout", zout_Multiply, 0);
    check("rst_product", productout_Multiply, 0);
    check("rst_idle", idle_Multiply, 0);
    @(posedge clock); #1 reset = 1'b1;

    // Hidden-bit squares, exponent 0+0+1
    run({1'b0, 8'h00, 24'h800000}, {1'b0, 8'h00, 24'h800000}, NO_IDLE,
        33'h0_0100_0000, 50'h1_0000_0000_0000, 1'b0, N_LAT);
    // All-ones mantissas, mixed signs
    run({1'b0, 8'h05, 24'hFFFFFF}, {1'b1, 8'hFD, 24'hFFFFFF}, NO_IDLE,
        33'h1_0300_0000, 50'h3_FFFF_F800_0004, 1'b0, N_LAT);
    // Pass-through completes at E0
    run(33'h0_7F80_0000, 33'h1_2345_6789, PUT_IDLE,
        33'h0_7F80_0000, 50'h0, 1'b1, 0);
    // Exponent wrap cases
    run({1'b0, 8'h7F, 24'h800000}, {1'b0, 8'h7F, 24'h800000}, NO_IDLE,
        33'h0_FF00_0000, 50'h1_0000_0000_0000, 1'b0, N_LAT);
    run({1'b0, 8'h80, 24'h800000}, {1'b0, 8'h80, 24'h800000}, NO_IDLE,
        33'h0_0100_0000, 50'h1_0000_0000_0000, 1'b0, N_LAT);
    // Zero mantissa: product 0, exponent rule unchanged
    run({1'b0, 8'h10, 24'h000000}, {1'b1, 8'h02, 24'h123456}, NO_IDLE,
        33'h1_1300_0000, 50'h0, 1'b0, N_LAT);

    // Random operands against the reference model
    for (int i = 0; i < 6; i++) begin
      a = {1'($urandom), 8'($urandom), 1'b1, 23'($urandom)};
      b = {1'($urandom), 8'($urandom), 24'($urandom)};
      run(a, b, NO_IDLE, model_z(a, b), model_p(a, b), 1'b0, N_LAT);
    end

    // Back-pressure in DONE with in_valid held high
    @(posedge clock); #1 out_ready = 1'b0;
    a = {1'b1, 8'h21, 24'hA5A5A5};
    b = {1'b0, 8'h0C, 24'h5A5A5A};
    send(a, b, NO_IDLE, model_z(a, b), model_p(a, b), 1'b0, 1'b1, 1'b1);
    aout_Special = 33'h0_0500_0001;
    bout_Special = 33'h0_0600_0003;
    wait_done(N_LAT);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("hold_in_ready", in_ready, 0);
      check("hold_out_valid", out_valid, 1);
      check("hold_product", productout_Multiply, model_p(a, b));
    end
    @(posedge clock); #1 out_ready = 1'b1;
    @(negedge clock);
    @(posedge clock); #1 in_valid = 1'b0;
    @(negedge clock);
    check("release_in_ready", in_ready, 1);
    check("release_out_valid", out_valid, 0);

    // Reset on the 6th CALC edge abandons the pair
    send({1'b0, 8'h11, 24'hC00001}, {1'b0, 8'h22, 24'hF0000F}, NO_IDLE,
         '0, '0, 1'b0, 1'b0, 1'b0);
    repeat (5) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_zout", zout_Multiply, 0);
    check("abort_product", productout_Multiply, 0);
    check("abort_idle", idle_Multiply, 0);
    @(posedge clock); #1 reset = 1'b1;
    ghost = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (out_valid) ghost++;
    end
    check("abort_no_result", ghost, 0);

    // One more transaction after the abort
    a = {1'b1, 8'hF0, 24'hFFFFFF};
    b = {1'b1, 8'h0F, 24'h800001};
    run(a, b, NO_IDLE, model_z(a, b), model_p(a, b), 1'b0, N_LAT);

    @(posedge clock);
    repeat (2) @(negedge clock);
    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
